// File: rtl/sync_counter_pkg.sv
// Shared constants for the synchronous counter library.
package sync_counter_pkg;
    localparam int   DEF_WIDTH = 4;     // default counter width
    localparam logic RST_VAL   = 1'b0;  // every counter bit clears to 0
    localparam logic DIR_UP    = 1'b1;  // up/down counter direction: increment
    localparam logic DIR_DOWN  = 1'b0;  // up/down counter direction: decrement
endpackage

// File: rtl/sync_tff.sv
// Toggle flip-flop with asynchronous active-low clear.
module sync_tff
    import sync_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    // Flip the stored bit on each enabled rising edge; clear immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)   q <= RST_VAL;
        else if (t) q <= ~q;
    end
endmodule

// File: rtl/sync_counter_bank.sv
// Three free-running synchronous counters (up, down, up/down) built from
// toggle flip-flops and ripple-free AND enable chains.
module sync_counter_bank
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    output logic [WIDTH-1:0] q_up,
    output logic [WIDTH-1:0] q_down,
    output logic [WIDTH-1:0] q_updown
);
    // Enable chains: entry i is the AND of bits [i-1:0] (all ones / all zeros).
    logic [WIDTH-1:0] en_up;     // q_up lower bits all 1
    logic [WIDTH-1:0] en_down;   // q_down lower bits all 0
    logic [WIDTH-1:0] ud_ones;   // q_updown lower bits all 1
    logic [WIDTH-1:0] ud_zeros;  // q_updown lower bits all 0
    logic [WIDTH-1:0] t_ud;      // q_updown toggle enables after direction select

    assign en_up[0]    = 1'b1;
    assign en_down[0]  = 1'b1;
    assign ud_ones[0]  = 1'b1;
    assign ud_zeros[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_chain
            assign en_up[i]    = en_up[i-1]    &  q_up[i-1];
            assign en_down[i]  = en_down[i-1]  & ~q_down[i-1];
            assign ud_ones[i]  = ud_ones[i-1]  &  q_updown[i-1];
            assign ud_zeros[i] = ud_zeros[i-1] & ~q_updown[i-1];
        end

        for (i = 0; i < WIDTH; i++) begin : g_bit
            // up only steers toggle enables, so outputs stay pure flop outputs.
            assign t_ud[i] = (up == DIR_UP) ? ud_ones[i] : ud_zeros[i];

            sync_tff u_up     (.clk(clk), .rst(rst), .t(en_up[i]),   .q(q_up[i]));
            sync_tff u_down   (.clk(clk), .rst(rst), .t(en_down[i]), .q(q_down[i]));
            sync_tff u_updown (.clk(clk), .rst(rst), .t(t_ud[i]),    .q(q_updown[i]));
        end
    endgenerate
endmodule

// File: tb/tb_sync_counter_bank.sv
// Directed self-checking bench for sync_counter_bank (WIDTH=4).
module tb_sync_counter_bank;
    import sync_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up  = DIR_UP;
    logic [3:0] q_up, q_down, q_updown;
    int         n_tests = 0;
    int         n_fail  = 0;

    sync_counter_bank #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .up(up),
        .q_up(q_up), .q_down(q_down), .q_updown(q_updown)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held low across several edges: all outputs stay 0.
    task automatic test_reset();
        rst = 1'b0;
        up  = DIR_UP;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({q_up, q_down, q_updown} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: got %h/%h/%h want 0/0/0", k, q_up, q_down, q_updown);
            end
        end
    endtask

    // Release reset with up=1; first five edges.
    task automatic test_count5();
        logic [3:0] exp_up [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [3:0] exp_dn [5] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
        @(negedge clk);
        up  = DIR_UP;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (q_up !== exp_up[k] || q_down !== exp_dn[k] || q_updown !== exp_up[k]) begin
                n_fail++;
                $display("FAIL count5 edge %0d: got up=%h dn=%h ud=%h want up=%h dn=%h ud=%h",
                         k+1, q_up, q_down, q_updown, exp_up[k], exp_dn[k], exp_up[k]);
            end
        end
    endtask

    // From q_updown=5: down twice (4,3), then up once (4).
    task automatic test_dir_change();
        logic       dir    [3] = '{DIR_DOWN, DIR_DOWN, DIR_UP};
        logic [3:0] exp_ud [3] = '{4'd4, 4'd3, 4'd4};
        logic [3:0] exp_up [3] = '{4'd6, 4'd7, 4'd8};
        logic [3:0] exp_dn [3] = '{4'd10, 4'd9, 4'd8};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            up = dir[k];
            step();
            n_tests++;
            if (q_updown !== exp_ud[k] || q_up !== exp_up[k] || q_down !== exp_dn[k]) begin
                n_fail++;
                $display("FAIL dir_change step %0d: got up=%h dn=%h ud=%h want up=%h dn=%h ud=%h",
                         k, q_up, q_down, q_updown, exp_up[k], exp_dn[k], exp_ud[k]);
            end
        end
    endtask

    // Reset asserted between edges clears outputs without a clock edge; counting resumes from 0.
    task automatic test_mid_reset();
        up = DIR_UP;
        step();  // q_up=9, q_down=7, q_updown=5
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({q_up, q_down, q_updown} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h/%h/%h want 0/0/0", q_up, q_down, q_updown);
        end
        step();
        n_tests++;
        if ({q_up, q_down, q_updown} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %h/%h/%h want 0/0/0", q_up, q_down, q_updown);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_tests++;
        if (q_up !== 4'd1 || q_down !== 4'd15 || q_updown !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got %h/%h/%h want 1/f/1", q_up, q_down, q_updown);
        end
    endtask

    // 17 edges from 0: up wraps f->0 at edge 16, down goes 1->0->f at edges 15..17.
    task automatic test_wrap();
        logic [3:0] e_up, e_dn;
        @(negedge clk);
        rst = 1'b0;
        up  = DIR_UP;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            e_up = 4'(k);
            e_dn = 4'(16 - k);
            n_tests++;
            if (q_up !== e_up || q_updown !== e_up || q_down !== e_dn) begin
                n_fail++;
                $display("FAIL wrap edge %0d: got up=%h dn=%h ud=%h want up=%h dn=%h ud=%h",
                         k, q_up, q_down, q_updown, e_up, e_dn, e_up);
            end
        end
    endtask

    // q_updown from 0 with up=0 goes to f then e; the other counters are unaffected.
    task automatic test_down_through_zero();
        logic [3:0] exp_ud [2] = '{4'd15, 4'd14};
        logic [3:0] exp_up [2] = '{4'd1, 4'd2};
        logic [3:0] exp_dn [2] = '{4'd15, 4'd14};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        up  = DIR_DOWN;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if (q_updown !== exp_ud[k] || q_up !== exp_up[k] || q_down !== exp_dn[k]) begin
                n_fail++;
                $display("FAIL down_zero edge %0d: got up=%h dn=%h ud=%h want up=%h dn=%h ud=%h",
                         k+1, q_up, q_down, q_updown, exp_up[k], exp_dn[k], exp_ud[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count5();
        test_dir_change();
        test_mid_reset();
        test_wrap();
        test_down_through_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
